controle_cronometro: RTL and testbench
======================================

Name: controle_cronometro

Overview:
Sequencing controller for the MM:SS countdown stopwatch. It owns the four BCD digit registers (seconds units, seconds tens, minutes units, minutes tens), the one-second prescaler, and the run/pause/done state machine. It replaces per-digit preset/reset wiring with a single load/start/clear command interface. Its digit outputs drive the display decoders directly.

Parameters:
TICK_DIV, 50000000, clk1 cycles per one-second tick (>=2); prescaler width = clog2(TICK_DIV)
ALARM_SECS, 5, seconds alarme stays high after reaching 00:00 (only with CRONO_ALARME_EN)

Ports:
clk1  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low; clears all state
start_pause  input  1  synchronous level; rising edge detected internally (one registered delay)
clear  input  1  synchronous level; returns to IDLE with 00:00
load  input  1  synchronous level; copies preset digits into the digit registers
preset_min_d  input  4  BCD minutes tens (0-9)
preset_min_u  input  4  BCD minutes units (0-9)
preset_seg_d  input  4  BCD seconds tens (0-5)
preset_seg_u  input  4  BCD seconds units (0-9)
min_d, min_u, seg_d, seg_u  output  4 each  current BCD digits
running  output  1  high in RUN
done  output  1  high in DONE
tick  output  1  one-cycle pulse on each second decrement
alarme  output  1  alarm drive (see Optional Feature)

Behaviour:
- Reset (reset=0, async): state IDLE, all digits 0, prescaler 0, edge register 0, running=0, done=0, tick=0, alarme=0.
- States: IDLE, RUN, PAUSE, DONE. Outputs are registered.
- Command priority within a cycle: clear > load > start_pause edge.
- clear in any state: next state IDLE, digits 00:00, prescaler 0.
- load: accepted in IDLE, PAUSE, DONE and ignored in RUN. Digits take preset values on the next edge, and the state becomes IDLE. Clamping: any digit >9 loads as 9, and preset_seg_d >5 loads as 5.
- start edge: IDLE with nonzero value -> RUN with prescaler cleared to 0. IDLE with 00:00 -> stays IDLE. RUN -> PAUSE with prescaler held. PAUSE -> RUN with prescaler resumed from its held value. DONE -> IDLE with digits left at 00:00.
- RUN: prescaler increments each cycle. When it equals TICK_DIV-1, it wraps to 0, tick=1 for that cycle, and the value decrements by 1 s.
- Decrement borrow chain:
  - seg_u 0->9 borrows from seg_d.
  - seg_d 0->5 borrows from min_u.
  - min_u 0->9 borrows from min_d.
- Latency: first tick occurs TICK_DIV cycles after entering RUN from IDLE.
- Reaching zero: the tick that makes the value 00:00 moves state to DONE in the same update, with done=1 on the following cycle and running=0. Digits never wrap below 00:00.
- In PAUSE and DONE, digits and prescaler are frozen and tick=0.
- Maximum value is 99:59 (5999 s), and a full countdown from it must complete without overflow.
- A held start_pause produces a single edge; re-triggering requires a low cycle.

Optional Feature:
CRONO_ALARME_EN:
- Defined: on entry to DONE, alarme=1 for ALARM_SECS x TICK_DIV cycles, timed by the prescaler, then 0. Any clear, load or start edge drops alarme immediately on the next edge.
- Undefined: the alarme port exists but is tied to 0, and no alarm timer logic is built.

Test Plan:
- TICK_DIV=4, load 00:03, start -> tick every 4 cycles; digits 00:02, 00:01, 00:00; done=1 one cycle after the 00:00 update; running=0.
- Load 10:00, start, one tick -> 09:59; borrow across all digits is correct; continue to 08:59 after 60 ticks.
- Start, pause after 2 prescaler cycles, wait 20 cycles, resume -> next tick 2 cycles after resume; digits unchanged during PAUSE.
- Load 00:00 and start -> stays IDLE, running=0. Load with preset_seg_d=7, preset_seg_u=12 -> 00:59.
- clear, load and start asserted in the same cycle while in RUN -> IDLE, 00:00. load alone in RUN -> ignored, count continues.
- Assert reset mid-RUN at value 05:17 -> all outputs 0 immediately, asynchronously. With CRONO_ALARME_EN and ALARM_SECS=2, TICK_DIV=4 -> alarme high exactly 8 cycles after entering DONE.

Source files
------------

// File: rtl/controle_cronometro.sv
// MM:SS countdown stopwatch controller: BCD digit registers, one-second prescaler, run/pause/done FSM.
// Optional alarm output is built only when CRONO_ALARME_EN is defined; otherwise alarme is tied low.
module controle_cronometro #(
  parameter int TICK_DIV   = 50000000,
  parameter int ALARM_SECS = 5
) (
  input  logic       clk1,
  input  logic       reset,
  input  logic       start_pause,
  input  logic       clear,
  input  logic       load,
  input  logic [3:0] preset_min_d,
  input  logic [3:0] preset_min_u,
  input  logic [3:0] preset_seg_d,
  input  logic [3:0] preset_seg_u,
  output logic [3:0] min_d,
  output logic [3:0] min_u,
  output logic [3:0] seg_d,
  output logic [3:0] seg_u,
  output logic       running,
  output logic       done,
  output logic       tick,
  output logic       alarme
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    minTens_q, minTens_d, minUnits_q, minUnits_d;
  logic [3:0]    secTens_q, secTens_d, secUnits_q, secUnits_d;
  logic          startPrev_q;
  logic          running_q, running_d, done_q, done_d, tick_q, tick_d;

  logic          startEdge, isZero, isOne, wrap;
  logic [3:0]    decMinTens, decMinUnits, decSecTens, decSecUnits;
  logic [3:0]    ldMinTens, ldMinUnits, ldSecTens, ldSecUnits;

`ifdef CRONO_ALARME_EN
  localparam int AW = $clog2(ALARM_SECS + 1);
  logic [AW-1:0] alarmSecs_q, alarmSecs_d;
  logic          alarme_q, alarme_d;
`endif

  assign startEdge = start_pause & ~startPrev_q;
  assign wrap      = (presc_q == PRESC_LAST);
  assign isZero    = (minTens_q == 4'd0) && (minUnits_q == 4'd0) &&
                     (secTens_q == 4'd0) && (secUnits_q == 4'd0);
  assign isOne     = (minTens_q == 4'd0) && (minUnits_q == 4'd0) &&
                     (secTens_q == 4'd0) && (secUnits_q == 4'd1);

  assign ldMinTens  = (preset_min_d > 4'd9) ? 4'd9 : preset_min_d;
  assign ldMinUnits = (preset_min_u > 4'd9) ? 4'd9 : preset_min_u;
  assign ldSecTens  = (preset_seg_d > 4'd5) ? 4'd5 : preset_seg_d;
  assign ldSecUnits = (preset_seg_u > 4'd9) ? 4'd9 : preset_seg_u;

  // One-second decrement with the BCD borrow chain; never called on 00:00.
  always_comb begin
    decMinTens  = minTens_q;
    decMinUnits = minUnits_q;
    decSecTens  = secTens_q;
    decSecUnits = secUnits_q - 4'd1;
    if (secUnits_q == 4'd0) begin
      decSecUnits = 4'd9;
      if (secTens_q == 4'd0) begin
        decSecTens = 4'd5;
        if (minUnits_q == 4'd0) begin
          decMinUnits = 4'd9;
          decMinTens  = minTens_q - 4'd1;
        end else begin
          decMinUnits = minUnits_q - 4'd1;
        end
      end else begin
        decSecTens = secTens_q - 4'd1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    minTens_d  = minTens_q;
    minUnits_d = minUnits_q;
    secTens_d  = secTens_q;
    secUnits_d = secUnits_q;
    tick_d     = 1'b0;
`ifdef CRONO_ALARME_EN
    alarme_d    = alarme_q;
    alarmSecs_d = alarmSecs_q;
`endif
    if (clear) begin
      state_d    = IDLE;
      presc_d    = '0;
      minTens_d  = 4'd0;
      minUnits_d = 4'd0;
      secTens_d  = 4'd0;
      secUnits_d = 4'd0;
    end else if (load && (state_q != RUN)) begin
      state_d    = IDLE;
      minTens_d  = ldMinTens;
      minUnits_d = ldMinUnits;
      secTens_d  = ldSecTens;
      secUnits_d = ldSecUnits;
    end else begin
      case (state_q)
        IDLE: begin
          if (startEdge && !isZero) begin
            state_d = RUN;
            presc_d = '0;
          end
        end
        RUN: begin
          if (startEdge) begin
            state_d = PAUSE;
          end else if (wrap) begin
            presc_d    = '0;
            tick_d     = 1'b1;
            minTens_d  = decMinTens;
            minUnits_d = decMinUnits;
            secTens_d  = decSecTens;
            secUnits_d = decSecUnits;
            if (isOne) begin
              state_d = DONE;
`ifdef CRONO_ALARME_EN
              alarme_d    = 1'b1;
              alarmSecs_d = AW'(ALARM_SECS);
`endif
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: begin
          if (startEdge) state_d = RUN;
        end
        DONE: begin
          if (startEdge) begin
            state_d = IDLE;
`ifdef CRONO_ALARME_EN
          end else if (alarme_q) begin
            // The prescaler is reused here to time the alarm in whole seconds.
            if (wrap) begin
              presc_d = '0;
              if (alarmSecs_q == AW'(1)) alarme_d = 1'b0;
              else alarmSecs_d = alarmSecs_q - 1'b1;
            end else begin
              presc_d = presc_q + 1'b1;
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
`ifdef CRONO_ALARME_EN
    if (state_d != DONE) alarme_d = 1'b0;
`endif
    running_d = (state_d == RUN);
    done_d    = (state_d == DONE);
  end

  always_ff @(posedge clk1 or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      presc_q     <= '0;
      minTens_q   <= 4'd0;
      minUnits_q  <= 4'd0;
      secTens_q   <= 4'd0;
      secUnits_q  <= 4'd0;
      startPrev_q <= 1'b0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      tick_q      <= 1'b0;
`ifdef CRONO_ALARME_EN
      alarme_q    <= 1'b0;
      alarmSecs_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      minTens_q   <= minTens_d;
      minUnits_q  <= minUnits_d;
      secTens_q   <= secTens_d;
      secUnits_q  <= secUnits_d;
      startPrev_q <= start_pause;
      running_q   <= running_d;
      done_q      <= done_d;
      tick_q      <= tick_d;
`ifdef CRONO_ALARME_EN
      alarme_q    <= alarme_d;
      alarmSecs_q <= alarmSecs_d;
`endif
    end
  end

  assign min_d   = minTens_q;
  assign min_u   = minUnits_q;
  assign seg_d   = secTens_q;
  assign seg_u   = secUnits_q;
  assign running = running_q;
  assign done    = done_q;
  assign tick    = tick_q;
`ifdef CRONO_ALARME_EN
  assign alarme  = alarme_q;
`else
  assign alarme  = 1'b0;
`endif

endmodule

// File: tb/tb_controle_cronometro.sv
// Self-checking bench for controle_cronometro (TICK_DIV=4, ALARM_SECS=2); expected digits per tick
// come from a seconds-count model and are queued as a scoreboard.
module tb_controle_cronometro;

  localparam int TICK_DIV   = 4;
  localparam int ALARM_SECS = 2;

  logic       clk1, reset, start_pause, clear, load;
  logic [3:0] preset_min_d, preset_min_u, preset_seg_d, preset_seg_u;
  logic [3:0] min_d, min_u, seg_d, seg_u;
  logic       running, done, tick, alarme;
  logic [15:0] digits;

  int nChecks = 0;
  int nFails  = 0;
  logic [15:0] expQ[$];

  controle_cronometro #(.TICK_DIV(TICK_DIV), .ALARM_SECS(ALARM_SECS)) dut (
    .clk1(clk1), .reset(reset), .start_pause(start_pause), .clear(clear), .load(load),
    .preset_min_d(preset_min_d), .preset_min_u(preset_min_u),
    .preset_seg_d(preset_seg_d), .preset_seg_u(preset_seg_u),
    .min_d(min_d), .min_u(min_u), .seg_d(seg_d), .seg_u(seg_u),
    .running(running), .done(done), .tick(tick), .alarme(alarme)
  );

  assign digits = {min_d, min_u, seg_d, seg_u};

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  function automatic logic [15:0] toBcd(input int secs);
    int m, s;
    m = secs / 60;
    s = secs % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // Scoreboard consumer: every tick pulse must match the oldest queued expected value.
  always @(negedge clk1) begin
    if (reset === 1'b1 && tick === 1'b1) begin
      nChecks = nChecks + 1;
      if (expQ.size() == 0) begin
        nFails = nFails + 1;
        $display("[TB] FAIL tick_unexpected: got tick with digits %h, expected no tick", digits);
      end else begin
        logic [15:0] e;
        e = expQ.pop_front();
        if (digits !== e) begin
          nFails = nFails + 1;
          $display("[TB] FAIL tick_digits: got %h, expected %h", digits, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk1);
    #1;
  endtask

  task automatic doLoad(input logic [3:0] md, mu, sd, su);
    preset_min_d = md; preset_min_u = mu; preset_seg_d = sd; preset_seg_u = su;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic pulseStart();
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
  endtask

  task automatic doClear();
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start_pause = 1'b0; clear = 1'b0; load = 1'b0;
    preset_min_d = 4'd0; preset_min_u = 4'd0; preset_seg_d = 4'd0; preset_seg_u = 4'd0;
    cyc(3);
    nChecks = nChecks + 1;
    if (digits !== 16'h0000) begin nFails = nFails + 1; $display("[TB] FAIL reset_digits: got %h, expected 0000", digits); end
    nChecks = nChecks + 1;
    if ({running, done, tick, alarme} !== 4'b0000) begin
      nFails = nFails + 1;
      $display("[TB] FAIL reset_flags: got %b, expected 0000", {running, done, tick, alarme});
    end
    reset = 1'b1;
    cyc(2);
  endtask

  task automatic test_countdown();
    int highCycles;
    logic alarmSeen;
    doLoad(4'd0, 4'd0, 4'd0, 4'd3);
    nChecks = nChecks + 1;
    if (digits !== 16'h0003) begin nFails = nFails + 1; $display("[TB] FAIL load_003: got %h, expected 0003", digits); end
    expQ.push_back(toBcd(2)); expQ.push_back(toBcd(1)); expQ.push_back(toBcd(0));
    pulseStart();
    nChecks = nChecks + 1;
    if (running !== 1'b1) begin nFails = nFails + 1; $display("[TB] FAIL run_entry: got %b, expected 1", running); end
    for (int k = 0; k < 3; k++) begin
      cyc(TICK_DIV - 1);
      nChecks = nChecks + 1;
      if (tick !== 1'b0) begin nFails = nFails + 1; $display("[TB] FAIL tick_early%0d: got %b, expected 0", k, tick); end
      cyc(1);
      nChecks = nChecks + 1;
      if (tick !== 1'b1) begin nFails = nFails + 1; $display("[TB] FAIL tick_period%0d: got %b, expected 1", k, tick); end
    end
    nChecks = nChecks + 1;
    if ({done, running} !== 2'b10) begin nFails = nFails + 1; $display("[TB] FAIL done_entry: got done,running=%b, expected 10", {done, running}); end
`ifdef CRONO_ALARME_EN
    highCycles = 0;
    while (alarme === 1'b1 && highCycles < 30) begin
      highCycles++;
      cyc(1);
    end
    nChecks = nChecks + 1;
    if (highCycles != ALARM_SECS * TICK_DIV) begin
      nFails = nFails + 1;
      $display("[TB] FAIL alarm_len: got %0d cycles, expected %0d", highCycles, ALARM_SECS * TICK_DIV);
    end
`else
    alarmSeen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      alarmSeen = alarmSeen | alarme;
      cyc(1);
    end
    nChecks = nChecks + 1;
    if (alarmSeen !== 1'b0) begin nFails = nFails + 1; $display("[TB] FAIL alarm_tied: got %b, expected 0", alarmSeen); end
`endif
    nChecks = nChecks + 1;
    if (digits !== 16'h0000 || done !== 1'b1) begin
      nFails = nFails + 1; $display("[TB] FAIL done_frozen: got %h done=%b, expected 0000 done=1", digits, done);
    end
    pulseStart();
    nChecks = nChecks + 1;
    if ({done, running, digits} !== 18'h0) begin
      nFails = nFails + 1; $display("[TB] FAIL done_to_idle: got %b %b %h, expected 0 0 0000", done, running, digits);
    end
  endtask

  task automatic test_borrow();
    int guard;
    doLoad(4'd1, 4'd0, 4'd0, 4'd0);
    for (int s = 599; s >= 539; s--) expQ.push_back(toBcd(s));
    pulseStart();
    guard = 0;
    while (expQ.size() != 0 && guard < 61 * TICK_DIV + 20) begin guard++; cyc(1); end
    nChecks = nChecks + 1;
    if (expQ.size() != 0) begin nFails = nFails + 1; $display("[TB] FAIL borrow_timeout: got %0d pending, expected 0", expQ.size()); end
    nChecks = nChecks + 1;
    if (digits !== 16'h0859 || running !== 1'b1) begin
      nFails = nFails + 1; $display("[TB] FAIL borrow_0859: got %h run=%b, expected 0859 run=1", digits, running);
    end
    doClear();
  endtask

  task automatic test_pause();
    logic tickSeen, changed;
    doLoad(4'd0, 4'd0, 4'd0, 4'd5);
    expQ.push_back(toBcd(4));
    pulseStart();
    cyc(2);
    pulseStart();
    nChecks = nChecks + 1;
    if (running !== 1'b0) begin nFails = nFails + 1; $display("[TB] FAIL pause_entry: got %b, expected 0", running); end
    tickSeen = 1'b0; changed = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tickSeen = tickSeen | tick;
      if (digits !== 16'h0005) changed = 1'b1;
      cyc(1);
    end
    nChecks = nChecks + 1;
    if ({tickSeen, changed} !== 2'b00) begin
      nFails = nFails + 1; $display("[TB] FAIL pause_frozen: got tick,changed=%b, expected 00", {tickSeen, changed});
    end
    pulseStart();
    nChecks = nChecks + 1;
    if ({running, tick} !== 2'b10) begin nFails = nFails + 1; $display("[TB] FAIL resume0: got %b, expected 10", {running, tick}); end
    cyc(1);
    nChecks = nChecks + 1;
    if (tick !== 1'b0) begin nFails = nFails + 1; $display("[TB] FAIL resume1: got %b, expected 0", tick); end
    cyc(1);
    nChecks = nChecks + 1;
    if (tick !== 1'b1) begin nFails = nFails + 1; $display("[TB] FAIL resume2_tick: got %b, expected 1", tick); end
    cyc(1);
    nChecks = nChecks + 1;
    if (expQ.size() != 0) begin nFails = nFails + 1; $display("[TB] FAIL pause_pending: got %0d, expected 0", expQ.size()); end
    doClear();
  endtask

  task automatic test_zero_and_clamp();
    doLoad(4'd0, 4'd0, 4'd0, 4'd0);
    pulseStart();
    cyc(6);
    nChecks = nChecks + 1;
    if ({running, done, tick} !== 3'b000) begin
      nFails = nFails + 1; $display("[TB] FAIL zero_start: got %b, expected 000", {running, done, tick});
    end
    doLoad(4'd0, 4'd0, 4'd7, 4'd12);
    nChecks = nChecks + 1;
    if (digits !== 16'h0059) begin nFails = nFails + 1; $display("[TB] FAIL clamp_0059: got %h, expected 0059", digits); end
  endtask

  task automatic test_priority();
    doLoad(4'd0, 4'd0, 4'd3, 4'd0);
    pulseStart();
    cyc(1);
    preset_min_d = 4'd1; preset_min_u = 4'd2; preset_seg_d = 4'd3; preset_seg_u = 4'd4;
    clear = 1'b1; load = 1'b1; start_pause = 1'b1;
    cyc(1);
    clear = 1'b0; load = 1'b0; start_pause = 1'b0;
    nChecks = nChecks + 1;
    if ({running, digits} !== 17'h0) begin
      nFails = nFails + 1; $display("[TB] FAIL prio_clear: got run=%b %h, expected run=0 0000", running, digits);
    end
    doLoad(4'd0, 4'd0, 4'd3, 4'd0);
    pulseStart();
    cyc(1);
    expQ.push_back(toBcd(29));
    doLoad(4'd0, 4'd7, 4'd0, 4'd7);
    nChecks = nChecks + 1;
    if (digits !== 16'h0030 || running !== 1'b1) begin
      nFails = nFails + 1; $display("[TB] FAIL load_in_run: got %h run=%b, expected 0030 run=1", digits, running);
    end
    cyc(2);
    nChecks = nChecks + 1;
    if (tick !== 1'b1) begin nFails = nFails + 1; $display("[TB] FAIL run_continues: got %b, expected 1", tick); end
    cyc(1);
    doClear();
  endtask

  task automatic test_held_start();
    doLoad(4'd0, 4'd0, 4'd1, 4'd0);
    expQ.push_back(toBcd(9)); expQ.push_back(toBcd(8));
    start_pause = 1'b1;
    cyc(10);
    nChecks = nChecks + 1;
    if (running !== 1'b1 || expQ.size() != 0) begin
      nFails = nFails + 1; $display("[TB] FAIL held_start: got run=%b pending=%0d, expected run=1 pending=0", running, expQ.size());
    end
    start_pause = 1'b0;
    cyc(1);
    pulseStart();
    nChecks = nChecks + 1;
    if (running !== 1'b0 || digits !== 16'h0008) begin
      nFails = nFails + 1; $display("[TB] FAIL retrigger: got run=%b %h, expected run=0 0008", running, digits);
    end
    doClear();
  endtask

  task automatic test_full_countdown();
    int guard;
    doLoad(4'd15, 4'd15, 4'd15, 4'd15);
    nChecks = nChecks + 1;
    if (digits !== 16'h9959) begin nFails = nFails + 1; $display("[TB] FAIL clamp_9959: got %h, expected 9959", digits); end
    for (int s = 5998; s >= 0; s--) expQ.push_back(toBcd(s));
    pulseStart();
    guard = 0;
    while (done !== 1'b1 && guard < 5999 * TICK_DIV + 40) begin guard++; cyc(1); end
    cyc(1);
    nChecks = nChecks + 1;
    if (done !== 1'b1 || digits !== 16'h0000 || expQ.size() != 0) begin
      nFails = nFails + 1;
      $display("[TB] FAIL full_countdown: got done=%b %h pending=%0d, expected done=1 0000 pending=0", done, digits, expQ.size());
    end
    doClear();
  endtask

  task automatic test_async_reset();
    doLoad(4'd0, 4'd5, 4'd1, 4'd8);
    expQ.push_back(toBcd(317));
    pulseStart();
    cyc(TICK_DIV);
    nChecks = nChecks + 1;
    if (digits !== 16'h0517 || running !== 1'b1) begin
      nFails = nFails + 1; $display("[TB] FAIL at_0517: got %h run=%b, expected 0517 run=1", digits, running);
    end
    @(negedge clk1);
    #1;
    reset = 1'b0;
    #1;
    nChecks = nChecks + 1;
    if ({digits, running, done, tick, alarme} !== 20'h0) begin
      nFails = nFails + 1;
      $display("[TB] FAIL async_reset: got %h %b, expected 0000 0000", digits, {running, done, tick, alarme});
    end
    #1;
    reset = 1'b1;
    cyc(2);
    nChecks = nChecks + 1;
    if (expQ.size() != 0) begin nFails = nFails + 1; $display("[TB] FAIL final_pending: got %0d, expected 0", expQ.size()); end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_borrow();
    test_pause();
    test_zero_and_clamp();
    test_priority();
    test_held_start();
    test_full_countdown();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
